// File: rtl/cam9t_pkg.sv
// Shared definitions for the 9T CAM array controller: command opcodes,
// controller states and an index-width helper.
package cam9t_pkg;

  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_SEARCH = 2'd2;
  localparam logic [1:0] OP_INVAL  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_W_SETUP = 4'd1,
    ST_W_PULSE = 4'd2,
    ST_W_HOLD  = 4'd3,
    ST_R_PRE   = 4'd4,
    ST_R_EVAL  = 4'd5,
    ST_S_PRE   = 4'd6,
    ST_S_EVAL  = 4'd7,
    ST_INVAL   = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/cam9t_prio_enc.sv
// Lowest-set-bit priority encoder; idx is 0 when no bit is set.
module cam9t_prio_enc
  import cam9t_pkg::*;
#(
  parameter int unsigned ROWS = 16,
  localparam int unsigned IW = clog2(ROWS)
) (
  input  logic [ROWS-1:0] vec,
  output logic            hit,
  output logic [IW-1:0]   idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (vec[i] && !hit) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cam9t_array_ctrl.sv
// Sequencing controller for a ROWS x WIDTH 9T CAM array: write, read,
// search and invalidate with per-row valid tracking.
module cam9t_array_ctrl
  import cam9t_pkg::*;
#(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WR_CYC   = 2,
  parameter int unsigned PRE_CYC  = 1,
  parameter int unsigned EVAL_CYC = 2,
  localparam int unsigned RW = clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [RW-1:0]    cmd_row,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [ROWS-1:0]  wlwr,
  output logic [WIDTH-1:0] dl,
  output logic [WIDTH-1:0] dlb,
  output logic [ROWS-1:0]  rwl,
  output logic             rbl_pre,
  input  logic [WIDTH-1:0] rbl,
  output logic             ml_pre,
  output logic [WIDTH-1:0] cam_data,
  input  logic [ROWS-1:0]  match,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic             hit,
  output logic [RW-1:0]    hit_idx,
  output logic [ROWS-1:0]  match_vec
);

  localparam int unsigned MAXC_WP = (WR_CYC > PRE_CYC) ? WR_CYC : PRE_CYC;
  localparam int unsigned MAXC    = (MAXC_WP > EVAL_CYC) ? MAXC_WP : EVAL_CYC;
  localparam int unsigned CW      = (MAXC > 1) ? clog2(MAXC) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ROWS-1:0]  valid_q, valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             hit_q, hit_d;
  logic [RW-1:0]    hit_idx_q, hit_idx_d;
  logic [ROWS-1:0]  match_vec_q, match_vec_d;

  logic [ROWS-1:0]  match_valid;
  logic             enc_hit;
  logic [RW-1:0]    enc_idx;
  logic [ROWS-1:0]  row_onehot;

  assign match_valid = match & valid_q;
  assign row_onehot  = ROWS'(1) << row_q;

  cam9t_prio_enc #(.ROWS(ROWS)) u_prio_enc (
    .vec (match_valid),
    .hit (enc_hit),
    .idx (enc_idx)
  );

  // cnt counts down the remaining cycles of the current phase; 0 = last cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    data_d      = data_q;
    valid_d     = valid_q;
    rd_data_d   = rd_data_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    match_vec_d = match_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          row_d  = cmd_row;
          data_d = cmd_data;
          cnt_d  = '0;
          case (cmd_op)
            OP_WRITE:  state_d = ST_W_SETUP;
            OP_READ: begin
              state_d = ST_R_PRE;
              cnt_d   = CW'(PRE_CYC - 1);
            end
            OP_SEARCH: begin
              state_d = ST_S_PRE;
              cnt_d   = CW'(PRE_CYC - 1);
            end
            OP_INVAL:  state_d = ST_INVAL;
          endcase
        end
      end
      ST_W_SETUP: begin
        state_d = ST_W_PULSE;
        cnt_d   = CW'(WR_CYC - 1);
      end
      ST_W_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_W_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_W_HOLD: begin
        valid_d[row_q] = 1'b1;
        state_d        = ST_DONE;
        cnt_d          = '0;
      end
      ST_R_PRE: begin
        if (cnt_q == '0) begin
          state_d = ST_R_EVAL;
          cnt_d   = CW'(EVAL_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_R_EVAL: begin
        if (cnt_q == '0) begin
          rd_data_d = ~rbl;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_S_PRE: begin
        if (cnt_q == '0) begin
          state_d = ST_S_EVAL;
          cnt_d   = CW'(EVAL_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_S_EVAL: begin
        if (cnt_q == '0) begin
          match_vec_d = match_valid;
          hit_d       = enc_hit;
          hit_idx_d   = enc_idx;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_INVAL: begin
        valid_d[row_q] = 1'b0;
        state_d        = ST_DONE;
        cnt_d          = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      data_q      <= '0;
      valid_q     <= '0;
      rd_data_q   <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      match_vec_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      match_vec_q <= match_vec_d;
    end
  end

  // Array lines decode straight from state so an async reset drops them at once.
  always_comb begin
    wlwr     = '0;
    rwl      = '0;
    dl       = '0;
    dlb      = '0;
    rbl_pre  = 1'b0;
    ml_pre   = 1'b0;
    cam_data = '0;
    case (state_q)
      ST_W_SETUP, ST_W_HOLD: begin
        dl  = data_q;
        dlb = ~data_q;
      end
      ST_W_PULSE: begin
        wlwr = row_onehot;
        dl   = data_q;
        dlb  = ~data_q;
      end
      ST_R_PRE:  rbl_pre = 1'b1;
      ST_R_EVAL: rwl = row_onehot;
      ST_S_PRE: begin
        ml_pre   = 1'b1;
        cam_data = data_q;
      end
      ST_S_EVAL: cam_data = data_q;
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rd_data   = rd_data_q;
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign match_vec = match_vec_q;

endmodule

// File: doc/cam9t_array_ctrl.md
Name: cam9t_array_ctrl

Overview:
- Sequencing controller for a ROWS x WIDTH array of 9T CAM cells: drives write wordlines/data lines, the read port, match-line precharge and the search key, then samples match lines.
- Accepts one command at a time (WRITE, READ, SEARCH, INVALIDATE) over a valid/ready handshake and returns results with a one-cycle done pulse.
- Keeps a per-row valid bit so that empty rows never report a hit.
- Sits between the system bus glue and the analog CAM array macro.

Parameters:
- ROWS, 16, number of CAM rows (power of 2, min 2)
- WIDTH, 8, bits per row
- WR_CYC, 2, cycles WLWR is held high per write (min 1)
- PRE_CYC, 1, precharge cycles before read/search evaluate (min 1)
- EVAL_CYC, 2, evaluate cycles before sampling RBL/MATCH (min 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  0=WRITE 1=READ 2=SEARCH 3=INVALIDATE
- cmd_row  in  log2(ROWS)  target row (WRITE/READ/INVALIDATE)
- cmd_data  in  WIDTH  write data or search key
- wlwr  out  ROWS  write wordlines, one-hot or zero
- dl  out  WIDTH  write bitlines
- dlb  out  WIDTH  complementary write bitlines
- rwl  out  ROWS  read wordlines, one-hot or zero
- rbl_pre  out  1  read-bitline precharge enable
- rbl  in  WIDTH  sensed read bitlines (low = stored 1)
- ml_pre  out  1  match-line precharge enable
- cam_data  out  WIDTH  search key driven to array
- match  in  ROWS  raw match lines (high = match)
- done  out  1  one-cycle completion pulse
- rd_data  out  WIDTH  read result, valid with done on READ
- hit  out  1  any valid row matched, valid with done on SEARCH
- hit_idx  out  log2(ROWS)  lowest matching valid row index
- match_vec  out  ROWS  match AND valid, registered

Behaviour:
- Reset (async):
  - State IDLE.
  - All outputs 0 except cmd_ready=1.
  - Valid bits cleared.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE.
  - Op, row and data are captured at acceptance; later changes to the inputs are ignored.
- WRITE:
  - W_SETUP (1 cyc): dl=data, dlb=~data.
  - W_PULSE (WR_CYC cyc): wlwr[row]=1, dl/dlb held.
  - W_HOLD (1 cyc): wlwr=0, dl/dlb held.
  - Then DONE; valid[row] is set.
  - Latency from acceptance to done = WR_CYC+3.
- READ:
  - R_PRE (PRE_CYC cyc): rbl_pre=1.
  - R_EVAL (EVAL_CYC cyc): rwl[row]=1, rbl_pre=0.
  - On the last eval cycle rd_data <= ~rbl, then DONE.
  - Reading an invalid row still returns the array contents.
- SEARCH:
  - S_PRE (PRE_CYC cyc): ml_pre=1, cam_data=key.
  - S_EVAL (EVAL_CYC cyc): ml_pre=0, cam_data held.
  - On the last eval cycle, match_vec <= match & valid, hit <= |match_vec, hit_idx <= priority-encode(lowest set bit). hit_idx=0 when no hit.
  - Then DONE.
- INVALIDATE: clears valid[row] in one cycle, then DONE. The array is not touched.
- DONE (1 cyc): done=1, then return to IDLE.
  - rd_data, hit, hit_idx and match_vec hold until the next completion of the same op type.
- Invariants:
  - wlwr and rwl are never both nonzero.
  - At most one bit of wlwr or rwl is set.
  - dl/dlb and cam_data are 0 outside their ops.
  - ml_pre and rbl_pre are mutually exclusive.
- Counters:
  - One phase counter, sized for max(WR_CYC, PRE_CYC, EVAL_CYC).
  - Reloaded on every state entry; the state advances when it reaches terminal value.
- Multiple matches: hit_idx reports the lowest index; match_vec shows all.
- Reset mid-operation: all lines drop to 0 immediately and valid bits clear. An in-flight write leaves the cell contents undefined, but the row is invalid.

Decomposition:
- Package cam9t_pkg holds:
  - op encoding constants (OP_WRITE, OP_READ, OP_SEARCH, OP_INVAL)
  - state enum typedef
  - clog2 helper for index width
- Sub-module cam9t_prio_enc (ROWS): combinational lowest-set-bit encoder producing hit and index.

Test Plan:
- Reset, then WRITE row 3 data 0xA5 with WR_CYC=2 -> wlwr=0x0008 for exactly 2 cycles, with dl=0xA5 and dlb=0x5A from setup through hold; done 5 cycles after acceptance; valid[3]=1.
- SEARCH key 0xA5 with the model asserting match[3] and match[7] (row 7 invalid) -> match_vec=0x0008, hit=1, hit_idx=3. Rows 3 and 9 both valid and matching -> hit_idx=3.
- SEARCH key 0x3C with no model matches -> hit=0, hit_idx=0, match_vec=0; ml_pre high exactly PRE_CYC cycles before evaluate.
- READ row 3 with the model driving rbl=~0xA5 -> rwl=0x0008 for EVAL_CYC cycles after PRE_CYC of rbl_pre; rd_data=0xA5 with done.
- INVALIDATE row 3, then SEARCH 0xA5 with match[3]=1 -> hit=0. Holding cmd_valid during a busy op -> cmd_ready=0 and no second acceptance until after done.
- Assert rst mid W_PULSE -> wlwr, dl and dlb are 0 in the same cycle, cmd_ready=1, all valid bits 0, no done pulse.
